mul_sequencer: RTL and testbench
================================

Name: mul_sequencer

Overview:
Multi-cycle controller for the EX-stage multiply.
- Detects a MUL request from ALU control.
- Runs an iterative radix-2 shift-add multiply over up to 32 cycles.
- Holds the pipeline with a stall while the multiply is in progress.
- Presents the low 32 bits of the product with a one-cycle done pulse, so the single-cycle ALU stays free of a wide combinational multiplier.

Parameters:
WIDTH, 32, operand/result width
CNT_W, 5, iteration counter width (log2 WIDTH)

Ports:
clk_i      in   1      clock; all state updates on rising edge
rst_i      in   1      reset, asynchronous, active-high
valid_i    in   1      EX stage holds a valid instruction
ALUCtl_i   in   4      ALU control code from ALU control; only `ALU_CTL_MUL triggers
flush_i    in   1      abort current instruction (branch/exception flush)
op_a_i     in   WIDTH  multiplicand (rs1 value)
op_b_i     in   WIDTH  multiplier (rs2 value)
stall_o    out  1      hold IF/ID/EX; high while a multiply is pending
result_o   out  WIDTH  low WIDTH bits of op_a_i*op_b_i; holds last value
done_o     out  1      one-cycle pulse, result_o valid this cycle

Behaviour:
- Reset values:
  - state=IDLE; acc, mcand, mplier, cnt = 0.
  - result_o=0, done_o=0.
  - stall_o forced 0 while rst_i high.
  - Reset mid-operation discards work; no done pulse.
- req = valid_i & (ALUCtl_i == `ALU_CTL_MUL) & ~flush_i.
- stall_o (combinational) = (state==IDLE & req) | (state==BUSY).
- IDLE:
  - On req: mcand<=op_a_i, mplier<=op_b_i, acc<=0, cnt<=0, go BUSY.
  - Non-MUL or invalid: block inert, stall_o=0.
- BUSY, once per cycle:
  - acc_next = acc + (mplier[0] ? mcand : 0), mod 2^WIDTH.
  - mcand <<= 1; mplier >>= 1; cnt++.
  - Go DONE when cnt==WIDTH-1 or (mplier>>1)==0 (early exit).
  - On the DONE transition: result_o<=acc_next, done_o<=1 registered.
- DONE:
  - done_o=1, stall_o=0; pipeline advances at this edge.
  - Next state unconditionally IDLE; valid_i/ALUCtl_i in DONE belong to the finishing instruction and are ignored (no restart).
- Latency:
  - Request accepted at cycle T.
  - done_o at T+1+k, where k = max(1, index of highest set bit of op_b_i + 1), capped at WIDTH.
  - b=0 -> T+2; b bit31 set -> T+33.
- Signedness: the low WIDTH bits are identical for signed and unsigned operands; no sign handling.
- Operands are latched at accept; later changes on op_a_i/op_b_i are ignored.
- flush_i:
  - In BUSY: next state IDLE, no done, result_o unchanged.
  - In IDLE: suppresses accept.
  - In DONE: done_o still pulses (result already committed; writeback gated downstream).
- Back-to-back MULs: the next accept occurs in the IDLE cycle after DONE; there is always one IDLE cycle between operations.
- result_o changes only on the BUSY->DONE edge.

Decomposition:
- Const.v holds `ALU_CTL_MUL (shared with ALU control) and the state encodings `MSEQ_IDLE/`MSEQ_BUSY/`MSEQ_DONE (2-bit).
- Optional sub-module mul_shift_add_dp: acc/mcand/mplier registers plus adder, controlled by load/step enables.
- The FSM, counter and stall logic stay in mul_sequencer.

Test Plan:
- Reset mid-BUSY (assert rst_i at T+5 of a 32-bit op) -> stall_o=0 immediately, state IDLE, no done_o, result_o=0.
- a=7, b=6, ALUCtl=MUL at T -> stall_o high T..T+3, done_o at T+4 only, result_o=42.
- a=0x12345678, b=0 -> done_o at T+2, result_o=0; stall_o high T..T+1.
- a=b=0xFFFFFFFF -> done_o at T+33, result_o=0x00000001; a=0xFFFFFFFD(-3), b=5 -> done_o at T+4, result_o=0xFFFFFFF1.
- flush_i at T+10 of a=3, b=0x80000000 -> IDLE at T+11, no done_o, stall_o low from T+11, result_o unchanged.
- Back-to-back: MUL 2*3, valid held through DONE, then MUL 4*5 -> done_o at T+3 (6), no restart in DONE; second accept at T+4, done_o at T+8 (20); ALUCtl=ADD -> stall_o never asserted.

Source files
------------

// File: rtl/mul_sequencer_pkg.sv
// Shared constants and types for the EX-stage multi-cycle multiply sequencer.
package mul_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    // ALU control codes, shared with the ALU control decoder.
    localparam int             ALU_CTL_W   = 4;
    localparam logic [3:0]     ALU_CTL_ADD = 4'b0010;
    localparam logic [3:0]     ALU_CTL_MUL = 4'b1010;

    typedef enum logic [1:0] {
        MSEQ_IDLE = 2'b00,
        MSEQ_BUSY = 2'b01,
        MSEQ_DONE = 2'b10
    } mseq_state_e;

    function automatic logic is_mul(input logic [ALU_CTL_W-1:0] ctl);
        return ctl == ALU_CTL_MUL;
    endfunction

endpackage

// File: rtl/mul_sequencer_dp.sv
// Shift-add datapath: accumulator, shifting multiplicand and multiplier.
// Controlled by load (capture operands, clear acc) and step (one radix-2 iteration).
module mul_shift_add_dp
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] op_a_i,
    input  logic [WIDTH-1:0] op_b_i,
    output logic [WIDTH-1:0] acc_next_o,
    output logic [WIDTH-1:0] mplier_o
);

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;

    // Partial sum for this iteration; wraps mod 2^WIDTH so only the low half survives.
    always_comb begin
        acc_next_o = acc_q + (mplier_q[0] ? mcand_q : '0);
        mplier_o   = mplier_q;
    end

    // Next-state for the datapath registers: load wins over step, otherwise hold.
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        if (load_i) begin
            acc_d    = '0;
            mcand_d  = op_a_i;
            mplier_d = op_b_i;
        end else if (step_i) begin
            acc_d    = acc_next_o;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/mul_sequencer.sv
// Multi-cycle multiply controller for the EX stage.
// Stalls the pipeline while an iterative shift-add multiply runs, then presents
// the low WIDTH bits of the product with a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for a MUL request; accepts and latches operands on req
// BUSY  | one shift-add iteration per cycle; stall held high
// DONE  | result_o valid, done_o high, pipeline released; always returns to IDLE
module mul_sequencer
    import mul_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    input  logic [ALU_CTL_W-1:0] ALUCtl_i,
    input  logic                 flush_i,
    input  logic [WIDTH-1:0]     op_a_i,
    input  logic [WIDTH-1:0]     op_b_i,
    output logic                 stall_o,
    output logic [WIDTH-1:0]     result_o,
    output logic                 done_o
);

    mseq_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;

    logic             req;
    logic             load;
    logic             step;
    logic             stall;
    logic             last_iter;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] mplier;

    mul_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (load),
        .step_i     (step),
        .op_a_i     (op_a_i),
        .op_b_i     (op_b_i),
        .acc_next_o (acc_next),
        .mplier_o   (mplier)
    );

    // Request decode and termination test; early exit once no multiplier bits remain.
    always_comb begin
        req       = valid_i & is_mul(ALUCtl_i) & ~flush_i;
        last_iter = (cnt_q == CNT_W'(WIDTH - 1)) | ((mplier >> 1) == '0);
    end

    // Next-state, counter, datapath enables and stall.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        load     = 1'b0;
        step     = 1'b0;
        stall    = 1'b0;
        case (state_q)
            MSEQ_IDLE: begin
                if (req) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    stall   = 1'b1;
                    state_d = MSEQ_BUSY;
                end
            end
            MSEQ_BUSY: begin
                stall = 1'b1;
                if (flush_i) begin
                    state_d = MSEQ_IDLE;
                end else begin
                    step  = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        result_d = acc_next;
                        done_d   = 1'b1;
                        state_d  = MSEQ_DONE;
                    end
                end
            end
            MSEQ_DONE: begin
                // Inputs seen here belong to the finishing instruction; never restart.
                state_d = MSEQ_IDLE;
            end
            default: begin
                state_d = MSEQ_IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= MSEQ_IDLE;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Stall is masked during reset so a held request cannot freeze the pipeline.
    always_comb begin
        stall_o  = stall & ~rst_i;
        result_o = result_q;
        done_o   = done_q;
    end

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: vector table plus multi-cycle corner sequences.
module tb_mul_sequencer;
    import mul_sequencer_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        int           lat;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        int           cyc;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_i;
    logic                 valid_i;
    logic [ALU_CTL_W-1:0] alu_ctl;
    logic                 flush_i;
    logic [W-1:0]         op_a;
    logic [W-1:0]         op_b;
    logic                 stall_o;
    logic [W-1:0]         result_o;
    logic                 done_o;

    int           checks   = 0;
    int           failures = 0;
    int           cyc      = 0;
    logic [W-1:0] last_res = '0;
    exp_t         sb_q[$];
    vec_t         vecs[8];

    mul_sequencer #(.WIDTH(W), .CNT_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .valid_i  (valid_i),
        .ALUCtl_i (alu_ctl),
        .flush_i  (flush_i),
        .op_a_i   (op_a),
        .op_b_i   (op_b),
        .stall_o  (stall_o),
        .result_o (result_o),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [W-1:0] r, input int c);
        exp_t e;
        e.res = r;
        e.cyc = c;
        sb_q.push_back(e);
    endtask

    // Negedge sample; any done pulse is matched against the scoreboard.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_result", result_o, e.res);
                check("sb_done_cycle", cyc, e.cyc);
            end
        end
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_vec(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] res, input int lat);
        int t;
        int stall_cnt;
        logic seen;
        t         = cyc;
        valid_i   = 1'b1;
        alu_ctl   = ALU_CTL_MUL;
        op_a      = a;
        op_b      = b;
        push_exp(res, t + 1 + lat);
        stall_cnt = 0;
        seen      = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            sample();
            if (done_o) begin
                seen = 1'b1;
                check("stall_at_done", 32'(stall_o), 32'd0);
            end else if (stall_o) begin
                stall_cnt++;
            end
            next_edge();
            if (n == 0) begin
                valid_i = 1'b0;
                op_a    = $urandom;
                op_b    = $urandom;
            end
        end
        check("done_seen", 32'(seen), 32'd1);
        check("stall_cycles", stall_cnt, lat + 1);
        sample();
        check("result_hold", result_o, res);
        check("stall_idle", 32'(stall_o), 32'd0);
        next_edge();
        last_res = res;
    endtask

    initial begin
        int t;
        int rel;

        vecs[0] = '{32'd7,          32'd6,          32'd42,         3};
        vecs[1] = '{32'h1234_5678,  32'd0,          32'd0,          1};
        vecs[2] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001,  32};
        vecs[3] = '{32'hFFFF_FFFD,  32'd5,          32'hFFFF_FFF1,  3};
        vecs[4] = '{32'd1,          32'd1,          32'd1,          1};
        vecs[5] = '{32'h0000_FFFF,  32'h0001_0000,  32'hFFFF_0000,  17};
        vecs[6] = '{32'd3,          32'h8000_0000,  32'h8000_0000,  32};
        vecs[7] = '{32'h0001_0001,  32'h0001_0001,  32'h0002_0001,  17};

        // Reset with a MUL request held: stall must stay low, outputs cleared.
        rst_i   = 1'b1;
        valid_i = 1'b1;
        alu_ctl = ALU_CTL_MUL;
        flush_i = 1'b0;
        op_a    = 32'd7;
        op_b    = 32'd6;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_stall", 32'(stall_o), 32'd0);
        check("reset_done", 32'(done_o), 32'd0);
        check("reset_result", result_o, 32'd0);
        @(posedge clk);
        #1;
        rst_i   = 1'b0;
        valid_i = 1'b0;
        sample();
        check("idle_stall", 32'(stall_o), 32'd0);
        next_edge();

        // Table of operand patterns.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].lat);
        end

        // Back-to-back: valid held through DONE must not restart there.
        t       = cyc;
        valid_i = 1'b1;
        alu_ctl = ALU_CTL_MUL;
        op_a    = 32'd2;
        op_b    = 32'd3;
        push_exp(32'd6, t + 3);
        for (int n = 0; n < 10; n++) begin
            sample();
            rel = cyc - t;
            if (rel == 3) check("b2b_stall_in_done", 32'(stall_o), 32'd0);
            if (rel == 4) check("b2b_stall_accept", 32'(stall_o), 32'd1);
            next_edge();
            rel = cyc - t;
            if (rel == 3) begin
                op_a = 32'd4;
                op_b = 32'd5;
            end
            if (rel == 4) push_exp(32'd20, t + 8);
            if (rel == 5) valid_i = 1'b0;
        end
        check("b2b_sb_empty", sb_q.size(), 0);
        last_res = 32'd20;

        // Flush in BUSY: abort with no done and result unchanged.
        t       = cyc;
        valid_i = 1'b1;
        alu_ctl = ALU_CTL_MUL;
        op_a    = 32'd3;
        op_b    = 32'h8000_0000;
        for (int n = 0; n < 40; n++) begin
            sample();
            rel = cyc - t;
            if (rel == 10) check("flush_stall_busy", 32'(stall_o), 32'd1);
            if (rel == 11) begin
                check("flush_stall_after", 32'(stall_o), 32'd0);
                check("flush_result_kept", result_o, last_res);
            end
            next_edge();
            rel = cyc - t;
            if (rel == 1)  valid_i = 1'b0;
            if (rel == 10) flush_i = 1'b1;
            if (rel == 11) flush_i = 1'b0;
        end
        check("flush_sb_empty", sb_q.size(), 0);
        check("flush_result_end", result_o, last_res);

        // Non-MUL op, then MUL suppressed by flush in IDLE: never stall, never done.
        valid_i = 1'b1;
        alu_ctl = ALU_CTL_ADD;
        op_a    = 32'd7;
        op_b    = 32'd6;
        for (int n = 0; n < 4; n++) begin
            sample();
            check("add_no_stall", 32'(stall_o), 32'd0);
            next_edge();
        end
        alu_ctl = ALU_CTL_MUL;
        flush_i = 1'b1;
        for (int n = 0; n < 3; n++) begin
            sample();
            check("flush_idle_no_stall", 32'(stall_o), 32'd0);
            next_edge();
        end
        valid_i = 1'b0;
        flush_i = 1'b0;
        for (int n = 0; n < 10; n++) begin
            sample();
            next_edge();
        end
        check("idle_result_kept", result_o, last_res);

        // Reset in the middle of a full-width multiply.
        t       = cyc;
        valid_i = 1'b1;
        alu_ctl = ALU_CTL_MUL;
        op_a    = 32'hFFFF_FFFF;
        op_b    = 32'hFFFF_FFFF;
        for (int n = 0; n < 5; n++) begin
            sample();
            next_edge();
            if (cyc - t == 1) valid_i = 1'b0;
        end
        rst_i = 1'b1;
        sample();
        check("midrst_stall", 32'(stall_o), 32'd0);
        check("midrst_done", 32'(done_o), 32'd0);
        check("midrst_result", result_o, 32'd0);
        next_edge();
        rst_i = 1'b0;
        for (int n = 0; n < 40; n++) begin
            sample();
            next_edge();
        end
        check("midrst_stall_idle", 32'(stall_o), 32'd0);
        check("midrst_result_end", result_o, 32'd0);
        check("midrst_sb_empty", sb_q.size(), 0);

        // Recovery after reset.
        run_vec(32'd9, 32'd11, 32'd99, 4);
        check("final_sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
